// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 SDF FFT stage sequencer.
// Stage state encoding, output tag bundle and the 2-bit bit-reversal used for twiddle order.
package fft_pkg;

  localparam int HALF  = 4;
  localparam int TW_AW = 3;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    SECOND,
    PEND,
    DRAIN
  } stage_st_t;

  typedef struct packed {
    logic vld;
    logic sof;
    logic eof;
  } tag_t;

  function automatic logic [1:0] bitrev2(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/fft_vld_pipe.sv
// Delays the {valid,sof,eof} tag of each control issue by DEPTH cycles to line up with stage data.
// Fixed latency DEPTH, never stalls; synchronous clear on rst.
module fft_vld_pipe
  import fft_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t in_tag,
  output tag_t out_tag,
  output logic any_vld
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = in_tag;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_vld = any_vld | pipe_q[i].vld;
    end
  end

  assign out_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_tw8_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage (8-sample frames, delay 4): delay-line, butterfly and twiddle control.
// Output tags lag control by LAT cycles; input is only refused (in_ready=0) while the last frame drains.
module fft_tw8_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int DRAIN_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             flush,
  output logic             in_ready,
  output logic             dl_en,
  output logic             bf_sel,
  output logic [TW_AW-1:0] tw_addr,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic             err_sof
);

  localparam int ICW = $clog2(DRAIN_WAIT + 1);

  stage_st_t      state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic           pend_q, pend_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d;

  logic acc;
  logic last;
  logic misplaced;
  logic pipe_busy;
  tag_t issue;
  tag_t out_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      pend_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      pend_q     <= pend_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign last = (k_q == 2'(HALF - 1));

  // A sof anywhere but pos0 restarts the frame; the sample becomes pos0 of a new FIRST half.
  assign misplaced = acc & in_sof & (k_q != 2'd0) &
                     ((state_q == FIRST) | (state_q == SECOND));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    pend_d     = pend_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      IDLE: begin
        if (acc & in_sof) begin
          state_d = FIRST;
          k_d     = 2'd1;
        end
      end
      FIRST: begin
        if (misplaced) begin
          k_d    = 2'd1;
          pend_d = 1'b0;
        end else if (acc) begin
          k_d = k_q + 2'd1;
          if (last) begin
            state_d = SECOND;
            pend_d  = 1'b0;
          end
        end
      end
      SECOND: begin
        if (misplaced) begin
          state_d = FIRST;
          k_d     = 2'd1;
          pend_d  = 1'b0;
        end else if (acc) begin
          k_d = k_q + 2'd1;
          if (last) begin
            state_d    = PEND;
            pend_d     = 1'b1;
            idle_cnt_d = '0;
          end
        end
      end
      PEND: begin
        if (acc & in_sof) begin
          state_d = FIRST;
          k_d     = 2'd1;
        end else if (flush) begin
          state_d = DRAIN;
        end else if (in_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == ICW'(DRAIN_WAIT - 1)) begin
          state_d = DRAIN;
        end else begin
          idle_cnt_d = idle_cnt_q + ICW'(1);
        end
      end
      DRAIN: begin
        k_d = k_q + 2'd1;
        if (last) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q != DRAIN);
    acc      = in_valid & in_ready & ~rst;
    dl_en    = 1'b0;
    bf_sel   = 1'b0;
    tw_addr  = '0;
    issue    = '0;
    err_sof  = 1'b0;
    case (state_q)
      IDLE: begin
        dl_en   = acc & in_sof;
        err_sof = acc & ~in_sof;
      end
      FIRST: begin
        dl_en = acc;
        if (misplaced) begin
          err_sof = 1'b1;
        end else if (pend_q) begin
          tw_addr   = {bitrev2(k_q), 1'b1};
          issue.vld = acc;
          issue.eof = acc & last;
        end
      end
      SECOND: begin
        dl_en = acc;
        if (misplaced) begin
          err_sof = 1'b1;
        end else begin
          bf_sel    = 1'b1;
          issue.vld = acc;
          issue.sof = acc & (k_q == 2'd0);
        end
      end
      PEND: begin
        // A new frame here is pos0 of FIRST and carries the first pending diff.
        if (acc & in_sof) begin
          dl_en     = 1'b1;
          tw_addr   = {bitrev2(k_q), 1'b1};
          issue.vld = 1'b1;
        end else begin
          err_sof = acc;
        end
      end
      DRAIN: begin
        dl_en     = ~rst;
        tw_addr   = {bitrev2(k_q), 1'b1};
        issue.vld = ~rst;
        issue.eof = ~rst & last;
      end
      default: ;
    endcase
  end

  fft_vld_pipe #(
    .DEPTH (LAT)
  ) u_vld_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_tag  (issue),
    .out_tag (out_tag),
    .any_vld (pipe_busy)
  );

  assign out_valid = out_tag.vld;
  assign out_sof   = out_tag.sof;
  assign out_eof   = out_tag.eof;
  assign busy      = (state_q != IDLE) | pipe_busy;

endmodule

// File: tb/tb_fft_tw8_stage_ctrl.sv
// Directed bench for fft_tw8_stage_ctrl (LAT=2, DRAIN_WAIT=8): vector table for a single frame,
// then per-cycle traces for back-to-back, stalled, misplaced-sof, flush and reset sequences.
module tb_fft_tw8_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       flush = 1'b0;
  logic       in_ready, dl_en, bf_sel;
  logic [2:0] tw_addr;
  logic       out_valid, out_sof, out_eof, busy, err_sof;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ov_t, os_t, oe_t, dl_t, rdy_t, err_t;

  always #5 clk = ~clk;

  fft_tw8_stage_ctrl #(
    .LAT        (2),
    .DRAIN_WAIT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .flush     (flush),
    .in_ready  (in_ready),
    .dl_en     (dl_en),
    .bf_sel    (bf_sel),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy),
    .err_sof   (err_sof)
  );

  typedef struct {
    logic       v, s, f;
    logic       dl, bf;
    logic [2:0] tw;
    logic       ov, os, oe, rdy, bsy, err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic v, s, f, dl, bf, input logic [2:0] tw,
                              input logic ov, os, oe, rdy, bsy, err);
    vec_t r;
    r.v = v; r.s = s; r.f = f; r.dl = dl; r.bf = bf; r.tw = tw;
    r.ov = ov; r.os = os; r.oe = oe; r.rdy = rdy; r.bsy = bsy; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input logic v, input logic s, input logic f);
    in_valid = v;
    in_sof   = s;
    flush    = f;
    @(negedge clk);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_traces;
    ov_t = '0; os_t = '0; oe_t = '0; dl_t = '0; rdy_t = '0; err_t = '0;
  endtask

  task automatic rec(input int c);
    ov_t[c]  = out_valid;
    os_t[c]  = out_sof;
    oe_t[c]  = out_eof;
    dl_t[c]  = dl_en;
    rdy_t[c] = in_ready;
    err_t[c] = err_sof;
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; flush = 1'b0;
    nxt();
    @(negedge clk);
    if (check) begin
      chk("rst_out_valid", -1, out_valid, 1'b0);
      chk("rst_out_sof",   -1, out_sof,   1'b0);
      chk("rst_out_eof",   -1, out_eof,   1'b0);
      chk("rst_busy",      -1, busy,      1'b0);
      chk("rst_in_ready",  -1, in_ready,  1'b1);
      chk("rst_dl_en",     -1, dl_en,     1'b0);
      chk("rst_tw_addr",   -1, tw_addr,   3'b000);
      chk("rst_err_sof",   -1, err_sof,   1'b0);
    end
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [7:0]  bf_seq;
    logic [2:0]  tw_or;
    logic [11:0] tw_seq;

    //                 v  s  f   dl bf tw      ov os oe rdy bsy err
    tbl[0]  = mk(1, 1, 0,  1, 0, 3'b000,  0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0,  1, 0, 3'b000,  0, 0, 0, 1, 1, 0);
    tbl[2]  = mk(1, 0, 0,  1, 0, 3'b000,  0, 0, 0, 1, 1, 0);
    tbl[3]  = mk(1, 0, 0,  1, 0, 3'b000,  0, 0, 0, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0,  1, 1, 3'b000,  0, 0, 0, 1, 1, 0);
    tbl[5]  = mk(1, 0, 0,  1, 1, 3'b000,  0, 0, 0, 1, 1, 0);
    tbl[6]  = mk(1, 0, 0,  1, 1, 3'b000,  1, 1, 0, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0,  1, 1, 3'b000,  1, 0, 0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 0,  0, 0, 3'b000,  1, 0, 0, 1, 1, 0);
    tbl[9]  = mk(0, 0, 0,  0, 0, 3'b000,  1, 0, 0, 1, 1, 0);
    for (int i = 10; i < 16; i++) tbl[i] = mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 1, 0);
    tbl[16] = mk(0, 0, 0,  1, 0, 3'b001,  0, 0, 0, 0, 1, 0);
    tbl[17] = mk(0, 0, 0,  1, 0, 3'b101,  0, 0, 0, 0, 1, 0);
    tbl[18] = mk(0, 0, 0,  1, 0, 3'b011,  1, 0, 0, 0, 1, 0);
    tbl[19] = mk(0, 0, 0,  1, 0, 3'b111,  1, 0, 0, 0, 1, 0);
    tbl[20] = mk(0, 0, 0,  0, 0, 3'b000,  1, 0, 0, 1, 1, 0);
    tbl[21] = mk(0, 0, 0,  0, 0, 3'b000,  1, 0, 1, 1, 1, 0);
    tbl[22] = mk(0, 0, 0,  0, 0, 3'b000,  0, 0, 0, 1, 0, 0);
    tbl[23] = mk(0, 0, 0,  0, 0, 3'b000,  0, 0, 0, 1, 0, 0);

    // Single frame, then idle until autonomous drain.
    do_reset(1'b1);
    for (int c = 0; c < 24; c++) begin
      apply(tbl[c].v, tbl[c].s, tbl[c].f);
      chk("t1_dl_en",     c, dl_en,     tbl[c].dl);
      chk("t1_bf_sel",    c, bf_sel,    tbl[c].bf);
      chk("t1_tw_addr",   c, tw_addr,   tbl[c].tw);
      chk("t1_out_valid", c, out_valid, tbl[c].ov);
      chk("t1_out_sof",   c, out_sof,   tbl[c].os);
      chk("t1_out_eof",   c, out_eof,   tbl[c].oe);
      chk("t1_in_ready",  c, in_ready,  tbl[c].rdy);
      chk("t1_busy",      c, busy,      tbl[c].bsy);
      chk("t1_err_sof",   c, err_sof,   tbl[c].err);
      nxt();
    end

    // Two back-to-back frames; previous frame's diffs ride in the next FIRST half.
    do_reset(1'b0);
    clr_traces();
    tw_seq = '0;
    for (int c = 0; c < 32; c++) begin
      apply(c < 16, (c == 0) || (c == 8), 1'b0);
      rec(c);
      if (c >= 8 && c < 12) tw_seq = {tw_seq[8:0], tw_addr};
      nxt();
    end
    chk("t2_out_valid_trace", 0, ov_t,  32'h3C03FFC0);
    chk("t2_out_sof_trace",   0, os_t,  32'h00004040);
    chk("t2_out_eof_trace",   0, oe_t,  32'h20002000);
    chk("t2_in_ready_trace",  0, rdy_t, 32'hF0FFFFFF);
    chk("t2_pend_tw_seq",     8, {20'd0, tw_seq}, 32'h35F);

    // Stalled frame: every other cycle valid.
    do_reset(1'b0);
    clr_traces();
    bf_seq = '0; tw_or = '0; tw_seq = '0; cnt = 0;
    for (int c = 0; c < 32; c++) begin
      apply((c < 16) && (c % 2 == 0), c == 0, 1'b0);
      rec(c);
      if (c < 16 && dl_en) begin
        bf_seq[c/2] = bf_sel;
        tw_or       = tw_or | tw_addr;
      end
      if (!in_ready) tw_seq = {tw_seq[8:0], tw_addr};
      if (out_valid) cnt++;
      nxt();
    end
    chk("t3_dl_en_trace", 0, {16'd0, dl_t[15:0]}, 32'h5555);
    chk("t3_bf_sel_seq",  0, bf_seq, 8'hF0);
    chk("t3_tw_frame",    0, tw_or, 3'b000);
    chk("t3_drain_tw",    0, {20'd0, tw_seq}, 32'h35F);
    chk("t3_issue_count", 0, cnt, 8);

    // sof at SECOND pos1 aborts the frame and restarts.
    do_reset(1'b0);
    clr_traces();
    for (int c = 0; c < 30; c++) begin
      apply(c < 13, (c == 0) || (c == 5), 1'b0);
      rec(c);
      nxt();
    end
    chk("t4_err_sof_trace",   0, err_t, 32'h00000020);
    chk("t4_out_valid_trace", 0, ov_t,  32'h07807840);
    chk("t4_out_sof_trace",   0, os_t,  32'h00000840);
    chk("t4_out_eof_trace",   0, oe_t,  32'h04000000);

    // flush one cycle after PEND entry; inputs during DRAIN are refused.
    do_reset(1'b0);
    clr_traces();
    for (int c = 0; c < 24; c++) begin
      apply((c < 8) || (c == 11) || (c == 12) || (c >= 14 && c < 22),
            (c == 0) || (c == 11) || (c == 12) || (c == 14),
            c == 9);
      rec(c);
      nxt();
    end
    chk("t5_in_ready_trace",  0, rdy_t, 32'h00FFC3FF);
    chk("t5_dl_en_trace",     0, dl_t,  32'h003FFCFF);
    chk("t5_out_valid_trace", 0, ov_t,  32'h00F0F3C0);
    chk("t5_out_sof_trace",   0, os_t,  32'h00100040);
    chk("t5_out_eof_trace",   0, oe_t,  32'h00008000);
    chk("t5_err_sof_trace",   0, err_t, 32'h00000000);

    // Reset in the middle of DRAIN.
    do_reset(1'b0);
    cnt = 0;
    for (int c = 0; c < 26; c++) begin
      rst = (c == 17);
      apply(c < 8, c == 0, 1'b0);
      if (c == 16) chk("t6_in_drain", c, in_ready, 1'b0);
      if (c == 18) begin
        chk("t6_out_valid", c, out_valid, 1'b0);
        chk("t6_busy",      c, busy,      1'b0);
        chk("t6_in_ready",  c, in_ready,  1'b1);
      end
      if (c >= 18 && out_valid) cnt++;
      nxt();
    end
    rst = 1'b0;
    chk("t6_no_late_output", 18, cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
